// File: rtl/output_drain_pkg.sv
// output_drain_pkg: shared types, default sizes and the lowest-set-bit helper
package output_drain_pkg;
  typedef enum logic {IDLE, DRAIN} state_e;
  localparam int DEF_BUS_WIDTH = 8;
  localparam int DEF_N_OPS = 5;
  localparam int DEF_IDX_W = $clog2(DEF_N_OPS);
  // Index of the lowest set bit of a mask of up to 64 bits; 0 when empty.
  function automatic int unsigned lowest_set(input logic [63:0] m);
    lowest_set = 0;
    for (int i = 63; i >= 0; i--)
      if (m[i]) lowest_set = unsigned'(i);
  endfunction
endpackage

// File: rtl/output_drain_priority_pick.sv
// priority_pick: lowest set bit index of a mask plus an exactly-one-bit flag
module priority_pick
  import output_drain_pkg::*;
#(
  parameter int N  = DEF_N_OPS,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          onehot_o
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    idx_o    = IW'(lowest_set(64'(mask_i)));
    onehot_o = (mask_i != '0) && ((mask_i & (mask_i - ONE)) == '0);
  end
endmodule

// File: rtl/output_drain.sv
// output_drain: captures masked result words and drains them one per handshake
module output_drain
  import output_drain_pkg::*;
#(
  parameter  int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter  int N_OPS     = DEF_N_OPS,
  localparam int IDX_W     = $clog2(N_OPS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       load_i,
  input  logic [N_OPS-1:0]           load_mask_i,
  input  logic [N_OPS*BUS_WIDTH-1:0] results_i,
  output logic                       busy_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [BUS_WIDTH-1:0]       out_data_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic                       out_last_o,
  output logic                       done_o
);
  localparam logic [N_OPS-1:0] ONE = {{(N_OPS-1){1'b0}}, 1'b1};
  state_e               state_q, state_d;
  logic [N_OPS-1:0]     pend_q, pend_d;
  logic [BUS_WIDTH-1:0] hold_q [N_OPS];
  logic [BUS_WIDTH-1:0] hold_d [N_OPS];
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     cur_idx;
  logic                 cur_last;
  logic                 drain;
  priority_pick #(.N(N_OPS), .IW(IDX_W)) u_pick (
    .mask_i   (pend_q),
    .idx_o    (cur_idx),
    .onehot_o (cur_last)
  );
  // Outputs come straight from registers so an async reset clears them at once.
  always_comb begin
    drain       = state_q == DRAIN;
    busy_o      = drain;
    out_valid_o = drain;
    out_last_o  = drain && cur_last;
    out_idx_o   = drain ? cur_idx : '0;
    out_data_o  = drain ? hold_q[cur_idx] : '0;
    done_o      = done_q;
  end
  // Next state: capture in IDLE, retire the lowest pending slot per accepted transfer.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (load_i && load_mask_i != '0) begin
        state_d = DRAIN;
        pend_d  = load_mask_i;
        for (int i = 0; i < N_OPS; i++)
          if (load_mask_i[i]) hold_d[i] = results_i[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end else if (out_ready_i) begin
      pend_d = pend_q & (pend_q - ONE);
      if (cur_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end
  // State, pending mask, holding words and the done pulse register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_OPS; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_output_drain.sv
// tb_output_drain: queue-based reference model, per-cycle compare and directed scenarios
module tb_output_drain;
  localparam int BW = 8;
  localparam int N  = 5;
  localparam int IW = $clog2(N);
  typedef struct {int idx; logic [BW-1:0] data;} ent_t;
  typedef struct {int idx; logic [BW-1:0] data; logic last;} log_t;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [N-1:0]      mask = '0;
  logic [N*BW-1:0]   res = '0;
  logic              ready = 1'b0;
  logic              busy, valid, last, done;
  logic [BW-1:0]     data;
  logic [IW-1:0]     idx;
  ent_t              q[$];
  logic              m_done = 1'b0;
  log_t              logq[$];
  int                busy_cnt = 0;
  int                done_cnt = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  output_drain dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (load),
    .load_mask_i (mask),
    .results_i   (res),
    .busy_o      (busy),
    .out_valid_o (valid),
    .out_ready_i (ready),
    .out_data_o  (data),
    .out_idx_o   (idx),
    .out_last_o  (last),
    .done_o      (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Reference model: the captured set is an ordered queue of (slot, word) pairs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (q.size() > 0) begin
        if (ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_done <= 1'b1;
        end
      end else if (load && mask != '0) begin
        for (int i = 0; i < N; i++)
          if (mask[i]) q.push_back('{i, res[i*BW +: BW]});
      end
    end
  end
  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    automatic bit ne = q.size() > 0;
    chk("busy", busy, ne);
    chk("out_valid", valid, ne);
    chk("out_last", last, q.size() == 1);
    chk("done", done, m_done);
    chk("out_idx", idx, ne ? q[0].idx : 0);
    chk("out_data", data, ne ? q[0].data : 0);
    if (done && valid) chk("done_and_valid", 1, 0);
  end
  // Transfer log and event counters for the directed literal checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) logq.push_back('{int'(idx), data, last});
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
  end
  initial begin
    int b0, d0, l0;
    logic [BW-1:0] bk1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_idx", idx, 0);
    tick();
    // Full mask, consumer always ready.
    b0 = busy_cnt; d0 = done_cnt; l0 = logq.size();
    ready = 1'b1; mask = 5'b11111; res = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; load = 1'b1;
    tick();
    load = 1'b0;
    chk("full_valid_after_one_clock", valid, 1);
    repeat (8) tick();
    chk("full_count", logq.size() - l0, 5);
    for (int k = 0; k < 5 && l0 + k < logq.size(); k++) begin
      chk("full_data", logq[l0+k].data, 8'h11 * (k + 1));
      chk("full_idx", logq[l0+k].idx, k);
      chk("full_last", logq[l0+k].last, k == 4);
    end
    chk("full_busy_cycles", busy_cnt - b0, 5);
    chk("full_done_pulses", done_cnt - d0, 1);
    // Sparse mask with three cycles of backpressure.
    l0 = logq.size();
    ready = 1'b0; mask = 5'b10010; res = {8'hA4, 8'h03, 8'h02, 8'hB1, 8'h00}; load = 1'b1;
    bk1 = 8'hB1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("bp_hold_idx", idx, 1);
      chk("bp_hold_data", data, bk1);
      chk("bp_hold_valid", valid, 1);
      tick();
    end
    ready = 1'b1;
    repeat (4) tick();
    chk("bp_count", logq.size() - l0, 2);
    if (logq.size() - l0 == 2) begin
      chk("bp_first_idx", logq[l0].idx, 1);
      chk("bp_first_data", logq[l0].data, 8'hB1);
      chk("bp_first_last", logq[l0].last, 0);
      chk("bp_second_idx", logq[l0+1].idx, 4);
      chk("bp_second_data", logq[l0+1].data, 8'hA4);
      chk("bp_second_last", logq[l0+1].last, 1);
    end
    // Single slot.
    l0 = logq.size(); d0 = done_cnt;
    mask = 5'b00100; res = {8'h0, 8'h0, 8'h77, 8'h0, 8'h0}; load = 1'b1;
    tick();
    load = 1'b0;
    #3;
    chk("single_last_first_cycle", last, 1);
    chk("single_idx", idx, 2);
    tick();
    #3;
    chk("single_done_next", done, 1);
    tick();
    chk("single_count", logq.size() - l0, 1);
    chk("single_done_pulses", done_cnt - d0, 1);
    // Load while busy, held through the final transfer.
    l0 = logq.size(); d0 = done_cnt;
    mask = 5'b00011; res = {8'h0, 8'h0, 8'h0, 8'hA1, 8'hA0}; load = 1'b1;
    tick();
    mask = 5'b11000; res = {8'hB4, 8'hB3, 8'hEE, 8'hEE, 8'hEE};
    tick();
    tick();
    chk("lwb_idle_gap_busy", busy, 0);
    tick();
    load = 1'b0;
    repeat (5) tick();
    chk("lwb_count", logq.size() - l0, 4);
    if (logq.size() - l0 == 4) begin
      chk("lwb_w0", logq[l0].data, 8'hA0);
      chk("lwb_w1", logq[l0+1].data, 8'hA1);
      chk("lwb_w2_idx", logq[l0+2].idx, 3);
      chk("lwb_w2", logq[l0+2].data, 8'hB3);
      chk("lwb_w3", logq[l0+3].data, 8'hB4);
    end
    chk("lwb_done_pulses", done_cnt - d0, 2);
    // Zero mask load.
    b0 = busy_cnt; d0 = done_cnt;
    mask = '0; load = 1'b1;
    repeat (3) tick();
    load = 1'b0;
    tick();
    chk("zero_busy", busy_cnt - b0, 0);
    chk("zero_done", done_cnt - d0, 0);
    // Reset mid-drain after the second word is accepted.
    l0 = logq.size(); d0 = done_cnt;
    mask = 5'b11111; res = {8'h95, 8'h94, 8'h93, 8'h92, 8'h91}; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_busy_immediate", busy, 0);
    chk("rst_valid_immediate", valid, 0);
    chk("rst_data_immediate", data, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_words", logq.size() - l0, 2);
    chk("rst_no_done", done_cnt - d0, 0);
    l0 = logq.size();
    mask = 5'b01000; res = {8'h0, 8'h5A, 8'h0, 8'h0, 8'h0}; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    chk("rst_after_count", logq.size() - l0, 1);
    if (logq.size() - l0 == 1) chk("rst_after_data", logq[l0].data, 8'h5A);
    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (reset) reset = 1'b0;
      load  = $urandom_range(0, 1) == 1;
      mask  = N'($urandom_range(0, 31));
      res   = {$urandom(), 8'($urandom())};
      ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 249) == 0) begin
        #2;
        reset = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    load = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
